// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute/memory control FSM for the 8-bit accumulator core.
// Owns the program counter, register-file write strobe, data-memory handshake and retire count.
module fetch_sequencer #(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] START_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      opcode,
  input  logic [1:0]      format,
  input  logic [PC_W-1:0] jmp_loc,
  input  logic            br_cond,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic            reg_we,
  output logic            mem_req,
  output logic            mem_we,
  output logic            busy,
  output logic            halted,
  output logic            mem_err,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LHB = 4'b0001;
  localparam logic [3:0] OP_JMP = 4'b0010;
  localparam logic [3:0] OP_STR = 4'b0011;
  localparam logic [3:0] OP_BNE = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BLT = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1110;
  localparam logic [3:0] OP_BLS = 4'b1111;
  localparam logic [1:0] FMT_X  = 2'b11;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     retired_reg, retired_next;
  logic [7:0]      tcnt_reg, tcnt_next;
  logic [3:0]      op_lat_reg, op_lat_next;

  logic [PC_W-1:0] pc_inc;
  logic [7:0]      tcnt_inc;
  logic            retire;

  assign pc_inc   = pc_reg + PC_W'(1);
  assign tcnt_inc = tcnt_reg + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      pc_reg      <= START_PC;
      retired_reg <= '0;
      tcnt_reg    <= '0;
      op_lat_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      retired_reg <= retired_next;
      tcnt_reg    <= tcnt_next;
      op_lat_reg  <= op_lat_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    retired_next = retired_reg;
    tcnt_next    = tcnt_reg;
    op_lat_next  = op_lat_reg;
    retire       = 1'b0;
    reg_we       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;

    case (state_reg)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_next   = S_FETCH;
          pc_next      = START_PC;
          retired_next = '0;
        end
      end

      S_FETCH: state_next = S_EXEC;

      S_EXEC: begin
        // An X-format word on anything but HALT is malformed; stop rather than guess.
        if (opcode == OP_HLT || format == FMT_X) begin
          state_next = S_HALT;
          retire     = 1'b1;
        end else begin
          case (opcode)
            OP_LB, OP_LHB, OP_STR: begin
              state_next  = S_MEM;
              tcnt_next   = '0;
              op_lat_next = opcode;
            end
            OP_JMP: begin
              pc_next    = jmp_loc;
              state_next = S_FETCH;
              retire     = 1'b1;
            end
            OP_BNE, OP_BEQ, OP_BLT, OP_BLS: begin
              pc_next    = br_cond ? jmp_loc : pc_inc;
              state_next = S_FETCH;
              retire     = 1'b1;
            end
            default: begin
              reg_we     = 1'b1;
              pc_next    = pc_inc;
              state_next = S_FETCH;
              retire     = 1'b1;
            end
          endcase
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_lat_reg == OP_STR);
        // Completion takes priority over a timeout landing in the same cycle.
        if (mem_ready) begin
          reg_we     = (op_lat_reg != OP_STR);
          pc_next    = pc_inc;
          state_next = S_FETCH;
          retire     = 1'b1;
        end else begin
          tcnt_next = tcnt_inc;
          if (tcnt_inc == TIMEOUT_CNT) begin
            state_next = S_ERR;
          end
        end
      end

      S_ERR: state_next = S_ERR;

      default: state_next = S_IDLE;
    endcase

    if (retire && retired_reg != 16'hFFFF) begin
      retired_next = retired_reg + 16'd1;
    end
  end

  assign pc      = pc_reg;
  assign retired = retired_reg;
  assign busy    = (state_reg == S_FETCH) || (state_reg == S_EXEC) || (state_reg == S_MEM);
  assign halted  = (state_reg == S_HALT);
  assign mem_err = (state_reg == S_ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a small ROM model and memory responder drive the core while
// a negedge monitor checks every reg_we / mem_req cycle against a queue of expected events.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, br_cond;
  logic        mem_ready = 1'b0;
  logic [3:0]  opcode;
  logic [1:0]  format;
  logic [15:0] jmp_loc, pc, retired;
  logic        reg_we, mem_req, mem_we, busy, halted, mem_err;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(16), .START_PC(16'h0000), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .format(format),
    .jmp_loc(jmp_loc), .br_cond(br_cond), .mem_ready(mem_ready), .pc(pc),
    .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .busy(busy),
    .halted(halted), .mem_err(mem_err), .retired(retired)
  );

  // Instruction ROM model, indexed by pc[8:0] so 0x0100 and 0xFFFF get their own slots.
  logic [3:0]  rom_op  [512];
  logic [1:0]  rom_fmt [512];
  logic [15:0] rom_jmp [512];
  assign opcode  = rom_op[pc[8:0]];
  assign format  = rom_fmt[pc[8:0]];
  assign jmp_loc = rom_jmp[pc[8:0]];

  typedef struct packed {
    logic [15:0] pc;
    logic        rw;
    logic        mr;
    logic        mw;
  } ev_t;

  ev_t exp_q[$];
  int  delay_q[$];
  bit  stall_forever = 1'b0;
  int  errors = 0;
  int  checks = 0;

  // Memory responder: each request gets mem_ready after the next queued number of wait cycles.
  bit active = 1'b0;
  int wait_cnt = 0;
  int cur_delay = 0;
  always @(posedge clk) begin
    #1;
    if (mem_req && !stall_forever) begin
      if (!active) begin
        active    = 1'b1;
        cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        wait_cnt  = 0;
      end
      if (wait_cnt == cur_delay) begin
        mem_ready = 1'b1;
        active    = 1'b0;
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      mem_ready = 1'b0;
      active    = 1'b0;
    end
  end

  always @(negedge clk) begin
    ev_t got, want;
    if (reg_we || mem_req) begin
      got.pc = pc;
      got.rw = reg_we;
      got.mr = mem_req;
      got.mw = mem_we;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: got pc=%h reg_we=%b mem_req=%b mem_we=%b, required no event",
                 got.pc, got.rw, got.mr, got.mw);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL event: got pc=%h reg_we=%b mem_req=%b mem_we=%b, required pc=%h reg_we=%b mem_req=%b mem_we=%b",
                   got.pc, got.rw, got.mr, got.mw, want.pc, want.rw, want.mr, want.mw);
        end else begin
          $display("ok   event pc=%h reg_we=%b mem_req=%b mem_we=%b", got.pc, got.rw, got.mr, got.mw);
        end
      end
    end
  end

  task automatic push(input logic [15:0] p, input logic rw, input logic mr, input logic mw);
    ev_t e;
    e.pc = p;
    e.rw = rw;
    e.mr = mr;
    e.mw = mw;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic flag(input int which);
    case (which)
      0:       return halted;
      1:       return mem_err;
      default: return mem_req;
    endcase
  endfunction

  task automatic wait_for(input int which, input int max, input string name);
    int n = 0;
    while (!flag(which) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (!flag(which)) begin
      errors++;
      $display("FAIL %s: got 0 required 1 within %0d cycles", name, max);
    end else begin
      $display("ok   %s after %0d cycles", name, n);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) begin
      rom_op[i]  = 4'hE;
      rom_fmt[i] = 2'b00;
      rom_jmp[i] = 16'h0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    br_cond = 1'b0;
    clear_rom();
    #3;
    check("reset pc", pc, 16'h0000);
    check("reset retired", retired, 16'h0000);
    check("reset outputs", {reg_we, mem_req, mem_we, busy, halted, mem_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("idle outputs", {reg_we, mem_req, mem_we, busy, halted, mem_err}, 0);

    // ALU sequence: LIM x3 then HALT
    for (int i = 0; i < 3; i++) begin
      rom_op[i]  = 4'b0100;
      rom_fmt[i] = 2'b01;
    end
    for (int i = 0; i < 3; i++) push(16'(i), 1'b1, 1'b0, 1'b0);
    pulse_start();
    check("alu fetch pc", pc, 16'h0000);
    check("alu busy", busy, 1);
    wait_for(0, 30, "alu halt");
    check("alu halt pc", pc, 16'h0003);
    check("alu retired", retired, 16'd4);
    check("alu busy in halt", busy, 0);

    // JMP to 5, BEQ taken to 10, HALT; restarted from HALT
    rom_op[0] = 4'b0010; rom_fmt[0] = 2'b00; rom_jmp[0] = 16'h0005;
    rom_op[5] = 4'b1011; rom_fmt[5] = 2'b00; rom_jmp[5] = 16'h000A;
    br_cond = 1'b1;
    pulse_start();
    check("restart pc", pc, 16'h0000);
    check("restart retired", retired, 16'h0000);
    step();
    check("jmp exec pc", pc, 16'h0000);
    step();
    check("jmp target pc", pc, 16'h0005);
    step(); step();
    check("beq taken pc", pc, 16'h000A);
    wait_for(0, 10, "beq taken halt");
    check("beq taken retired", retired, 16'd3);

    // BEQ not taken
    br_cond = 1'b0;
    pulse_start();
    step(); step(); step(); step();
    check("beq not taken pc", pc, 16'h0006);
    wait_for(0, 10, "beq not taken halt");
    check("beq not taken retired", retired, 16'd3);

    // JMP to 0x0100
    rom_jmp[0] = 16'h0100;
    pulse_start();
    step(); step();
    check("jmp 0x0100 pc", pc, 16'h0100);
    wait_for(0, 10, "jmp 0x0100 halt");
    check("jmp 0x0100 retired", retired, 16'd2);

    // LIM with X format behaves as HALT with no register write
    rom_op[0] = 4'b0100; rom_fmt[0] = 2'b11;
    pulse_start();
    step(); step();
    check("xfmt halted", halted, 1);
    check("xfmt pc", pc, 16'h0000);
    check("xfmt retired", retired, 16'd1);

    // Memory: LB waits 3, STR immediate, LHB waits 14 (ready on the timeout cycle)
    clear_rom();
    rom_op[0] = 4'b0000; rom_fmt[0] = 2'b10;
    rom_op[1] = 4'b0011; rom_fmt[1] = 2'b10;
    rom_op[2] = 4'b0001; rom_fmt[2] = 2'b10;
    delay_q.push_back(3);
    delay_q.push_back(0);
    delay_q.push_back(14);
    for (int i = 0; i < 3; i++) push(16'h0000, 1'b0, 1'b1, 1'b0);
    push(16'h0000, 1'b1, 1'b1, 1'b0);
    push(16'h0001, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) push(16'h0002, 1'b0, 1'b1, 1'b0);
    push(16'h0002, 1'b1, 1'b1, 1'b0);
    pulse_start();
    wait_for(0, 60, "mem halt");
    check("mem halt pc", pc, 16'h0003);
    check("mem retired", retired, 16'd4);
    check("mem no error", mem_err, 0);

    // pc wrap at 0xFFFF; start held high while busy must be ignored
    clear_rom();
    rom_op[0]   = 4'b0010; rom_jmp[0] = 16'hFFFF;
    rom_op[511] = 4'b0111;
    push(16'hFFFF, 1'b1, 1'b0, 1'b0);
    pulse_start();
    step();
    step();
    check("wrap pre pc", pc, 16'hFFFF);
    start = 1'b1;
    step();
    check("busy start pc", pc, 16'hFFFF);
    check("busy start busy", busy, 1);
    step();
    start = 1'b0;
    check("wrap pc", pc, 16'h0000);
    rom_op[0] = 4'hE;
    step(); step();
    check("wrap halted", halted, 1);
    check("wrap retired", retired, 16'd3);

    // Asynchronous reset in the middle of a memory wait
    clear_rom();
    rom_op[0] = 4'b0100; rom_fmt[0] = 2'b01;
    rom_op[1] = 4'b0000; rom_fmt[1] = 2'b10;
    stall_forever = 1'b1;
    push(16'h0000, 1'b1, 1'b0, 1'b0);
    push(16'h0001, 1'b0, 1'b1, 1'b0);
    pulse_start();
    wait_for(2, 10, "reach mem");
    check("mid-mem retired", retired, 16'd1);
    @(negedge clk); #2;
    check("mem_req before reset", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("mem_req async drop", mem_req, 0);
    check("async reset pc", pc, 16'h0000);
    check("async reset retired", retired, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Timeout: 15 stalled cycles then ERR, start ignored, reset recovers
    clear_rom();
    rom_op[0] = 4'b0000; rom_fmt[0] = 2'b10;
    for (int i = 0; i < 15; i++) push(16'h0000, 1'b0, 1'b1, 1'b0);
    pulse_start();
    wait_for(1, 40, "timeout err");
    check("err busy", busy, 0);
    check("err pc", pc, 16'h0000);
    check("err mem_req", mem_req, 0);
    check("err retired", retired, 16'h0000);
    pulse_start();
    step();
    check("err holds after start", mem_err, 1);
    check("err busy after start", busy, 0);
    stall_forever = 1'b0;
    rst_n = 1'b0;
    #1;
    check("err cleared by reset", mem_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("post reset outputs", {reg_we, mem_req, mem_we, busy, halted, mem_err}, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending events: got %0d left required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit accumulator-style core.
- Owns the 16-bit program counter that drives the instruction ROM.
- Consumes the decoded opcode and format, the jump target and the ALU branch condition.
- Sequences fetch, execute and data-memory access: register-file write enables, memory handshake, halt and error status, retired-instruction count.

Parameters:
PC_W, 16, program counter width.
START_PC, 0, PC value loaded at reset and on every start.
MEM_TIMEOUT, 15, max cycles waiting for mem_ready before error (1..255).

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins execution from START_PC when idle or halted
opcode  in  4  instr[7:4] from instruction ROM for current pc
format  in  2  C/I/M/X format from instruction ROM (C=00, I=01, M=10, X=11)
jmp_loc  in  PC_W  resolved jump/branch target from instruction ROM
br_cond  in  1  ALU compare result for the current branch opcode (1 = taken)
mem_ready  in  1  data memory completes the current request this cycle
pc  out  PC_W  current program counter to instruction ROM
reg_we  out  1  register-file write enable (single-cycle pulse)
mem_req  out  1  data-memory request, held until accepted
mem_we  out  1  data-memory write qualifier, valid with mem_req
busy  out  1  high in FETCH, EXEC, MEM
halted  out  1  high in HALT
mem_err  out  1  high in ERR
retired  out  16  count of completed instructions, saturating

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, HALT, ERR.
- Reset (async, rst_n=0): state=IDLE, pc=START_PC, retired=0, timeout counter=0.
- All outputs are 0 during reset and in IDLE, except pc.
- mem_req drops in the same instant reset asserts.
- IDLE: start=1 -> FETCH, pc=START_PC, retired=0.
- FETCH: one cycle for ROM output to settle; always -> EXEC.
- EXEC: decode opcode, one cycle:
  - 1110 HALT: -> HALT; pc unchanged; retired+1.
  - 0000 LB, 0001 LHB, 0011 STR: -> MEM; timeout counter cleared.
  - 0010 JMP: pc<=jmp_loc; -> FETCH; retired+1.
  - 1010 BNE, 1011 BEQ, 1100 BLT, 1111 BLS: pc<=jmp_loc if br_cond, else pc+1; -> FETCH; retired+1.
  - 0100 LIM, 0101 MVB, 0110 MVF, 0111 ADD, 1000 SUB, 1001 SFT, 1101 INC: reg_we=1 this cycle; pc<=pc+1; -> FETCH; retired+1.
  - format is checked for consistency only: an X format on a non-HALT opcode is treated as HALT.
- MEM:
  - mem_req=1 every cycle in MEM; mem_we=1 iff the latched opcode is STR.
  - The opcode is latched on EXEC->MEM so ROM changes cannot affect it.
  - mem_ready=1: reg_we=1 same cycle for LB/LHB (0 for STR); pc<=pc+1; retired+1; -> FETCH.
  - mem_ready=0: counter+1; on reaching MEM_TIMEOUT -> ERR, pc unchanged, mem_req drops next cycle.
  - mem_ready=1 in the same cycle the counter reaches the limit: completion wins.
- Timing:
  - ALU, jump and branch instructions take 2 cycles.
  - Memory instructions take 3 cycles plus wait cycles.
- HALT: halted=1, pc holds; start -> FETCH with pc=START_PC, retired cleared.
- ERR: mem_err=1, pc holds; exits only via rst_n; start ignored.
- start while busy is ignored.
- mem_ready outside MEM is ignored.
- pc+1 at 0xFFFF wraps to 0x0000.
- retired saturates at 0xFFFF.
- reg_we, mem_req and mem_we are decoded from registered state plus the latched or current opcode.
- busy, halted and mem_err are pure functions of state.

Test Plan:
- Reset, then start; ROM returns 0100 at pc 0..2 then 1110 -> reg_we pulses in the EXEC cycles at pc 0, 1, 2; halted=1 at pc=3; retired=4.
- BEQ at pc=5, jmp_loc=10: br_cond=1 -> next pc=10; repeat with br_cond=0 -> next pc=6; JMP to 0x0100 -> pc=0x0100 after 2 cycles.
- LB with mem_ready delayed 3 cycles -> mem_req high 4 cycles, mem_we=0, reg_we only in the ready cycle, pc+1; STR with immediate ready -> mem_we=1 for 1 cycle, no reg_we.
- mem_ready held 0 for 15 cycles -> mem_err=1, busy=0, pc frozen; start ignored; rst_n pulse -> IDLE, pc=0.
- rst_n asserted mid-MEM -> mem_req falls without waiting for a clock edge, retired=0; pc=0xFFFF with ADD -> pc wraps to 0x0000.
- start pulsed while busy -> no effect; start in HALT -> restart at START_PC with retired=0.
